// File: rtl/mips_reg_dump.sv
// mips_reg_dump: debug read-out engine for the MIPS register file.
// Walks a wrapping, inclusive range of register addresses through one
// read port and streams each value as an address/data beat on a
// valid/ready interface. While a scan is active, freeze asks the core
// to hold off register writes.
module mips_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              freeze,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] end_r;

  // State register. The control outputs are decoded from it, so the
  // asynchronous reset clears them at once, without waiting for a clock edge.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control-output decode. Abort beats a simultaneous handshake.
  // NOTE: every output gets a default before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        rd_addr   = idx;
        state_nxt = abort ? IDLE : SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort)          state_nxt = IDLE;
        else if (out_ready) state_nxt = out_last ? DONE : FETCH;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign freeze = busy;

  // Range registers and the output beat. The beat is captured at the edge
  // that ends FETCH, so a falling-edge write inside FETCH is still seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      end_r    <= '0;
      out_addr <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= start_addr;
            end_r <= end_addr;
          end
        end
        FETCH: begin
          if (!abort) begin
            out_data <= rd_data;
            out_addr <= idx;
            out_last <= (idx == end_r);
          end
        end
        SEND: begin
          if (!abort && out_ready && !out_last) begin
            idx <= (idx == LAST_REG) ? '0 : idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_reg_dump.sv
// Testbench for mips_reg_dump: a behavioural register file feeds rd_data,
// expected beats are queued when a scan starts and checked as the DUT
// hands them over.
module tb_mips_reg_dump;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          freeze;
  logic          done;

  logic [DW-1:0] regs [NR];
  beat_t         sb [$];
  int            errors = 0;
  int            checks = 0;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  mips_reg_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .freeze(freeze), .done(done)
  );

  task automatic push_range(input int s, input int e);
    int    n;
    int    a;
    beat_t b;
    n = (((e - s) % NR) + NR) % NR + 1;
    for (int k = 0; k < n; k++) begin
      a      = (s + k) % NR;
      b.addr = AW'(a);
      b.data = regs[a];
      b.last = (k == n - 1);
      sb.push_back(b);
    end
  endtask

  // Runs one scan from the start edge E0; done_edge is the k of the
  // cycle Ek..Ek+1 in which done was seen (-1 if never).
  task automatic run_scan(input int s, input int e, input int stall_beat,
                          input int stall_cycles, input bit pulse_start,
                          output int done_edge);
    int            edge_n;
    int            beats;
    int            stalled;
    bit            finished;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_addr;
    beat_t         eb;
    done_edge = -1;
    edge_n    = 0;
    beats     = 0;
    stalled   = 0;
    finished  = 0;
    held_data = '0;
    held_addr = '0;
    @(negedge clk);
    start = 1'b1; start_addr = AW'(s); end_addr = AW'(e);
    push_range(s, e);
    @(posedge clk);
    #1 start = 1'b0;
    while (!finished && edge_n < 400) begin
      @(negedge clk);
      start = pulse_start && (edge_n == 3);
      if (start) begin start_addr = 5'd20; end_addr = 5'd20; end
      out_ready = 1'b1;
      if (out_valid && beats == stall_beat && stalled < stall_cycles) begin
        out_ready = 1'b0;
        if (stalled == 0) begin
          held_data = out_data; held_addr = out_addr;
        end else begin
          checks++;
          if (out_data !== held_data || out_addr !== held_addr) begin
            errors++;
            $display("FAIL stall_hold: addr=%0d data=%h, want addr=%0d data=%h",
                     out_addr, out_data, held_addr, held_data);
          end
        end
        stalled++;
      end
      checks++;
      if (freeze !== busy) begin
        errors++;
        $display("FAIL freeze_eq_busy: freeze=%b busy=%b", freeze, busy);
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: addr=%0d, want no beat", out_addr);
        end else begin
          eb = sb[0];
          if (out_addr !== eb.addr || out_data !== eb.data || out_last !== eb.last) begin
            errors++;
            $display("FAIL beat: addr=%0d data=%h last=%b, want addr=%0d data=%h last=%b",
                     out_addr, out_data, out_last, eb.addr, eb.data, eb.last);
          end
          if (out_ready) begin
            void'(sb.pop_front());
            beats++;
          end
        end
      end else if (busy && !done && sb.size() > 0) begin
        checks++;
        if (rd_addr !== sb[0].addr) begin
          errors++;
          $display("FAIL rd_addr: got %0d, want %0d", rd_addr, sb[0].addr);
        end
      end
      if (done) begin
        done_edge = edge_n;
        finished  = 1;
      end else begin
        @(posedge clk);
        edge_n++;
      end
    end
    checks++;
    if (!finished || sb.size() != 0) begin
      errors++;
      $display("FAIL scan_end: finished=%0d left=%0d, want finished=1 left=0",
               finished, sb.size());
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL post_idle: busy=%b valid=%b done=%b rd_addr=%0d, want 0 0 0 0",
               busy, out_valid, done, rd_addr);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rd_addr, out_addr, out_data, out_valid, out_last, busy, freeze, done} !== '0) begin
      errors++;
      $display("FAIL %s: rd_addr=%0d addr=%0d data=%h valid=%b last=%b busy=%b freeze=%b done=%b, want all 0",
               name, rd_addr, out_addr, out_data, out_valid, out_last, busy, freeze, done);
    end
  endtask

  task automatic check_done_edge(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s_done_edge: got E%0d, want E%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #1 check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_full_scan();
    int de;
    run_scan(0, 31, -1, 0, 1'b0, de);
    check_done_edge("full", de, 64);
  endtask

  task automatic test_wrap();
    int de;
    run_scan(30, 1, -1, 0, 1'b0, de);
    check_done_edge("wrap", de, 8);
  endtask

  task automatic test_single();
    int de;
    regs[7] = 32'hDEAD_BEEF;
    run_scan(7, 7, -1, 0, 1'b0, de);
    check_done_edge("single", de, 2);
  endtask

  task automatic test_back_to_back_stall();
    int de;
    run_scan(0, 3, 2, 3, 1'b1, de);
    check_done_edge("backpressure", de, 11);
  endtask

  task automatic test_abort();
    int    beats;
    int    guard;
    int    de;
    beat_t eb;
    beats = 0;
    guard = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 5'd0; end_addr = 5'd31;
    push_range(0, 31);
    @(posedge clk);
    #1 start = 1'b0;
    out_ready = 1'b1;
    while (guard < 200) begin
      @(negedge clk);
      guard++;
      if (done) begin
        checks++; errors++;
        $display("FAIL abort_early_done: done=1 before abort, want 0");
      end
      if (out_valid) begin
        if (beats == 5) break;
        eb = sb.pop_front();
        checks++;
        if (out_addr !== eb.addr || out_data !== eb.data) begin
          errors++;
          $display("FAIL abort_beat: addr=%0d data=%h, want addr=%0d data=%h",
                   out_addr, out_data, eb.addr, eb.data);
        end
        beats++;
      end
    end
    checks++;
    if (beats != 5 || !out_valid) begin
      errors++;
      $display("FAIL abort_reach: beats=%0d valid=%b, want 5 1", beats, out_valid);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle[%0d]: valid=%b busy=%b done=%b, want 0 0 0",
                 i, out_valid, busy, done);
      end
    end
    sb.delete();
    run_scan(4, 4, -1, 0, 1'b0, de);
    check_done_edge("restart", de, 2);
  endtask

  task automatic test_reset_mid_scan();
    int de;
    regs[10] = 32'h1234_5678;
    @(negedge clk);
    start = 1'b1; start_addr = 5'd10; end_addr = 5'd15;
    @(posedge clk);
    #1 start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_addr !== 5'd10) begin
      errors++;
      $display("FAIL pre_reset_beat: valid=%b addr=%0d data=%h, want 1 10 12345678",
               out_valid, out_addr, out_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rd_addr !== 5'd11) begin
      errors++;
      $display("FAIL pre_reset_fetch: busy=%b valid=%b rd_addr=%0d, want 1 0 11",
               busy, out_valid, rd_addr);
    end
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_release");
    run_scan(3, 5, -1, 0, 1'b0, de);
    check_done_edge("post_reset", de, 6);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    test_reset();
    test_full_scan();
    test_wrap();
    test_single();
    test_back_to_back_stall();
    test_abort();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
